// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback path.
// Widths, the x0 address constant and the read-forwarding hit test.
package rf_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } rf_wr_req_t;

    // x0 never forwards: it reads as zero from the rf regardless of pending writes.
    function automatic logic fwd_hit(input logic          vld,
                                     input logic [AW-1:0] waddr,
                                     input logic [AW-1:0] raddr);
        return vld && (waddr == raddr) && (raddr != REG_ZERO);
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of writeback requests, rf write port and forwarded read ports.
// slave = arbiter side, master = requesters / rf / consumers side.
interface rf_wb_arbiter_if;
    import rf_pkg::*;

    logic            req0_valid;
    logic            req0_ready;
    logic [AW-1:0]   req0_addr;
    logic [XLEN-1:0] req0_data;
    logic            req1_valid;
    logic            req1_ready;
    logic [AW-1:0]   req1_addr;
    logic [XLEN-1:0] req1_data;
    logic            rf_hold;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [AW-1:0]   rd_addr1;
    logic [AW-1:0]   rd_addr2;
    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;
    logic [XLEN-1:0] rd_data1;
    logic [XLEN-1:0] rd_data2;
    logic            grant_last;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  rf_hold, rd_addr1, rd_addr2, rf_rdata1, rf_rdata2,
        output req0_ready, req1_ready,
        output rf_wen, rf_waddr, rf_wdata,
        output rd_data1, rd_data2, grant_last
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output rf_hold, rd_addr1, rd_addr2, rf_rdata1, rf_rdata2,
        input  req0_ready, req1_ready,
        input  rf_wen, rf_waddr, rf_wdata,
        input  rd_data1, rd_data2, grant_last
    );

endinterface

// File: rtl/rr_arb2.sv
// 2-way round-robin arbiter; the loser of a contested grant wins next time.
// Latency: combinational grant, pointer updates on the granting edge.
// Backpressure: no grant at all while i_advance is low; pointer then holds.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    logic r_prio;
    logic w_prio_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else begin
            r_prio <= w_prio_nxt;
        end
    end

    always_comb begin
        o_gnt      = 2'b00;
        w_prio_nxt = r_prio;
        if (i_advance) begin
            if (i_req == 2'b11) begin
                o_gnt = r_prio ? 2'b10 : 2'b01;
            end else begin
                o_gnt = i_req;
            end
        end
        // Point at the requester that was not served.
        if (o_gnt != 2'b00) begin
            w_prio_nxt = o_gnt[0];
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the rf write port between two writeback sources via a one-entry stage.
// Latency: accepted at edge N, rf_wen high in cycle N+1, rf written at edge N+1.
// Backpressure: only rf_hold stalls (no accept, no commit); otherwise always ready.
module rf_wb_arbiter
    import rf_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    rf_wb_arbiter_if.slave wb
);

    logic            w_accept;
    logic [1:0]      w_req;
    logic [1:0]      w_gnt;
    rf_wr_req_t      w_req0;
    rf_wr_req_t      w_req1;
    rf_wr_req_t      w_sel;

    logic            r_wb_valid;
    logic [AW-1:0]   r_wb_addr;
    logic [XLEN-1:0] r_wb_data;
    logic            r_grant_last;

    assign w_req0 = '{valid: wb.req0_valid, addr: wb.req0_addr, data: wb.req0_data};
    assign w_req1 = '{valid: wb.req1_valid, addr: wb.req1_addr, data: wb.req1_data};
    assign w_req  = {w_req1.valid, w_req0.valid};

    // Gating with rst_n keeps both readies low while reset is asserted.
    assign w_accept = ~wb.rf_hold & rst_n;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_req),
        .i_advance (w_accept),
        .o_gnt     (w_gnt)
    );

    always_comb begin
        w_sel       = w_gnt[1] ? w_req1 : w_req0;
        w_sel.valid = |w_gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid   <= 1'b0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
            r_grant_last <= 1'b0;
        end else if (!wb.rf_hold) begin
            if (w_sel.valid) begin
                // x0 writes take the grant but never reach the rf.
                r_wb_valid   <= (w_sel.addr != REG_ZERO);
                r_wb_addr    <= w_sel.addr;
                r_wb_data    <= w_sel.data;
                r_grant_last <= w_gnt[1];
            end else begin
                r_wb_valid   <= 1'b0;
            end
        end
    end

    assign wb.req0_ready = w_gnt[0];
    assign wb.req1_ready = w_gnt[1];
    assign wb.grant_last = r_grant_last;

    assign wb.rf_wen   = r_wb_valid & ~wb.rf_hold;
    assign wb.rf_waddr = r_wb_addr;
    assign wb.rf_wdata = r_wb_data;

    assign wb.rd_data1 = fwd_hit(r_wb_valid, r_wb_addr, wb.rd_addr1) ? r_wb_data : wb.rf_rdata1;
    assign wb.rd_data2 = fwd_hit(r_wb_valid, r_wb_addr, wb.rd_addr2) ? r_wb_data : wb.rf_rdata2;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a behavioural register file behind it.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter_if wb_if ();

    rf_wb_arbiter u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb_if)
    );

    logic [XLEN-1:0] mem [32] = '{default: '0};

    always @(posedge clk) begin
        if (wb_if.rf_wen && wb_if.rf_waddr != 0) mem[wb_if.rf_waddr] <= wb_if.rf_wdata;
    end

    assign wb_if.rf_rdata1 = mem[wb_if.rd_addr1];
    assign wb_if.rf_rdata2 = mem[wb_if.rd_addr2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n            = 1'b0;
        wb_if.req0_valid = 1'b1;
        wb_if.req0_addr  = 5'd1;
        wb_if.req0_data  = 32'h0;
        wb_if.req1_valid = 1'b0;
        wb_if.req1_addr  = 5'd0;
        wb_if.req1_data  = 32'h0;
        wb_if.rf_hold    = 1'b0;
        wb_if.rd_addr1   = 5'd0;
        wb_if.rd_addr2   = 5'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen",   {31'b0, wb_if.rf_wen},     32'd0);
        chk("rst_rdy0",  {31'b0, wb_if.req0_ready}, 32'd0);
        chk("rst_glast", {31'b0, wb_if.grant_last}, 32'd0);
        wb_if.req0_valid = 1'b0;
        rst_n = 1'b1;

        // Single write to x1
        cyc();
        wb_if.req0_valid = 1'b1; wb_if.req0_addr = 5'd1; wb_if.req0_data = 32'h01010101;
        wb_if.rd_addr1 = 5'd1;
        #1;
        chk("sw_rdy0",    {31'b0, wb_if.req0_ready}, 32'd1);
        chk("sw_rdy1",    {31'b0, wb_if.req1_ready}, 32'd0);
        chk("sw_wen_pre", {31'b0, wb_if.rf_wen},     32'd0);
        chk("sw_rd_pre",  wb_if.rd_data1,            32'h0);
        cyc();
        wb_if.req0_valid = 1'b0;
        #1;
        chk("sw_wen",   {31'b0, wb_if.rf_wen},     32'd1);
        chk("sw_waddr", {27'b0, wb_if.rf_waddr},   32'd1);
        chk("sw_wdata", wb_if.rf_wdata,            32'h01010101);
        chk("sw_fwd",   wb_if.rd_data1,            32'h01010101);
        chk("sw_glast", {31'b0, wb_if.grant_last}, 32'd0);
        cyc();
        #1;
        chk("sw_wen_post", {31'b0, wb_if.rf_wen}, 32'd0);
        chk("sw_rf",       wb_if.rd_data1,        32'h01010101);

        // x0 write from req1 (prio was 1 after req0's grant)
        cyc();
        wb_if.req1_valid = 1'b1; wb_if.req1_addr = 5'd0; wb_if.req1_data = 32'hDEADBEEF;
        wb_if.rd_addr1 = 5'd0;
        #1;
        chk("x0_rdy1", {31'b0, wb_if.req1_ready}, 32'd1);
        chk("x0_rdy0", {31'b0, wb_if.req0_ready}, 32'd0);
        cyc();
        wb_if.req1_valid = 1'b0;
        #1;
        chk("x0_wen",   {31'b0, wb_if.rf_wen},     32'd0);
        chk("x0_glast", {31'b0, wb_if.grant_last}, 32'd1);
        chk("x0_rd",    wb_if.rd_data1,            32'h0);

        // Contention: prio back at 0, grants go 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 0) begin
                wb_if.req0_valid = 1'b1; wb_if.req0_addr = 5'd2; wb_if.req0_data = 32'hAAAA0002;
                wb_if.req1_valid = 1'b1; wb_if.req1_addr = 5'd3; wb_if.req1_data = 32'hBBBB0003;
            end
            #1;
            chk("cn_rdy0", {31'b0, wb_if.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("cn_rdy1", {31'b0, wb_if.req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("cn_both", {31'b0, wb_if.req0_ready & wb_if.req1_ready}, 32'd0);
            if (k > 0) begin
                chk("cn_wen",   {31'b0, wb_if.rf_wen},     32'd1);
                chk("cn_waddr", {27'b0, wb_if.rf_waddr},   ((k - 1) % 2 == 1) ? 32'd3 : 32'd2);
                chk("cn_glast", {31'b0, wb_if.grant_last}, ((k - 1) % 2 == 1) ? 32'd1 : 32'd0);
            end
        end
        cyc();
        wb_if.req0_valid = 1'b0; wb_if.req1_valid = 1'b0;
        wb_if.rd_addr1 = 5'd2; wb_if.rd_addr2 = 5'd3;
        #1;
        chk("cn_tail_wen",   {31'b0, wb_if.rf_wen},     32'd1);
        chk("cn_tail_waddr", {27'b0, wb_if.rf_waddr},   32'd3);
        chk("cn_tail_glast", {31'b0, wb_if.grant_last}, 32'd1);
        cyc();
        #1;
        chk("cn_idle_wen", {31'b0, wb_if.rf_wen}, 32'd0);
        chk("cn_rf2",      wb_if.rd_data1,        32'hAAAA0002);
        chk("cn_rf3",      wb_if.rd_data2,        32'hBBBB0003);

        // Hold with a pending write to x5
        cyc();
        wb_if.req0_valid = 1'b1; wb_if.req0_addr = 5'd5; wb_if.req0_data = 32'h55;
        #1;
        chk("h_rdy0_acc", {31'b0, wb_if.req0_ready}, 32'd1);
        for (int h = 0; h < 3; h++) begin
            cyc();
            if (h == 0) begin
                wb_if.req0_valid = 1'b0;
                wb_if.rf_hold    = 1'b1;
                wb_if.req1_valid = 1'b1; wb_if.req1_addr = 5'd6; wb_if.req1_data = 32'h66;
                wb_if.rd_addr2   = 5'd5;
            end
            #1;
            chk("h_wen",  {31'b0, wb_if.rf_wen},     32'd0);
            chk("h_rdy0", {31'b0, wb_if.req0_ready}, 32'd0);
            chk("h_rdy1", {31'b0, wb_if.req1_ready}, 32'd0);
            chk("h_fwd",  wb_if.rd_data2,            32'h55);
        end
        cyc();
        wb_if.rf_hold = 1'b0;
        #1;
        chk("hr_wen",   {31'b0, wb_if.rf_wen},     32'd1);
        chk("hr_waddr", {27'b0, wb_if.rf_waddr},   32'd5);
        chk("hr_rdy1",  {31'b0, wb_if.req1_ready}, 32'd1);
        chk("hr_fwd",   wb_if.rd_data2,            32'h55);
        cyc();
        wb_if.req1_valid = 1'b0;
        #1;
        chk("hr2_waddr", {27'b0, wb_if.rf_waddr}, 32'd6);
        chk("hr2_rf5",   wb_if.rd_data2,          32'h55);
        cyc();
        #1;
        chk("hr3_wen", {31'b0, wb_if.rf_wen}, 32'd0);

        // Back-to-back writes to x7
        cyc();
        wb_if.req0_valid = 1'b1; wb_if.req0_addr = 5'd7; wb_if.req0_data = 32'd1;
        wb_if.rd_addr1 = 5'd7;
        #1;
        chk("bb_rdy0", {31'b0, wb_if.req0_ready}, 32'd1);
        cyc();
        wb_if.req0_data = 32'd2;
        #1;
        chk("bb1_wdata", wb_if.rf_wdata, 32'd1);
        chk("bb1_fwd",   wb_if.rd_data1, 32'd1);
        cyc();
        wb_if.req0_valid = 1'b0;
        #1;
        chk("bb2_wdata", wb_if.rf_wdata, 32'd2);
        chk("bb2_fwd",   wb_if.rd_data1, 32'd2);
        chk("bb2_rf",    mem[7],         32'd1);
        cyc();
        #1;
        chk("bb3_wen", {31'b0, wb_if.rf_wen}, 32'd0);
        chk("bb3_rd",  wb_if.rd_data1,        32'd2);
        chk("bb3_rf",  mem[7],                32'd2);

        // Reset with a pending write to x1; prio is 1 beforehand
        cyc();
        wb_if.req0_valid = 1'b1; wb_if.req0_addr = 5'd1; wb_if.req0_data = 32'hFFFF0001;
        wb_if.rd_addr1 = 5'd1;
        #1;
        chk("rr_rdy0", {31'b0, wb_if.req0_ready}, 32'd1);
        cyc();
        wb_if.req0_valid = 1'b0;
        #1;
        chk("rr_wen_pre", {31'b0, wb_if.rf_wen}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_wen", {31'b0, wb_if.rf_wen}, 32'd0);
        chk("rr_fwd", wb_if.rd_data1,        32'h01010101);
        cyc();
        chk("rr_x1", mem[1], 32'h01010101);
        rst_n = 1'b1;
        cyc();
        wb_if.req0_valid = 1'b1; wb_if.req0_addr = 5'd2; wb_if.req0_data = 32'h2;
        wb_if.req1_valid = 1'b1; wb_if.req1_addr = 5'd3; wb_if.req1_data = 32'h3;
        #1;
        chk("rr_glast", {31'b0, wb_if.grant_last}, 32'd0);
        chk("rr_prio0", {31'b0, wb_if.req0_ready}, 32'd1);
        chk("rr_prio1", {31'b0, wb_if.req1_ready}, 32'd0);
        cyc();
        wb_if.req0_valid = 1'b0; wb_if.req1_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
